// File: rtl/apb_mem_pkg.sv
// Shared types and helpers for the parametrised APB memory slave.
// The optional byte-strobe port is enabled with the APB_MEM_PSTRB_EN macro.
package apb_mem_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_e;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int STRB_W         = DEF_DATA_WIDTH / 8;

  // Ceiling log2, evaluated at elaboration for shift and index widths.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/apb_mem_array.sv
// Word storage for the APB memory slave: registered read port and a
// byte-enabled write port. Contents are not reset.
module apb_mem_array
  import apb_mem_pkg::*;
#(
  parameter int DEPTH      = 64,
  parameter int DATA_WIDTH = 32,
  parameter int IDX_W      = 6,
  parameter int SW         = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rd_en,
  input  logic [IDX_W-1:0]      rd_idx,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  wr_en,
  input  logic [IDX_W-1:0]      wr_idx,
  input  logic [SW-1:0]         wr_be,
  input  logic [DATA_WIDTH-1:0] wr_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;

  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) rd_data_d = mem[rd_idx];
  end

  always_ff @(posedge clk) begin
    if (wr_en)
      for (int b = 0; b < SW; b++)
        if (wr_be[b]) mem[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_data_q <= '0;
    else        rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/apb_mem_slave.sv
// Parametrised APB3/APB4 memory slave with programmable wait states and
// out-of-range error response. APB_MEM_PSTRB_EN adds the PSTRB port.
module apb_mem_slave
  import apb_mem_pkg::*;
#(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 64,
  parameter int WAIT_STATES = 0
) (
  input  logic                    PCLK,
  input  logic                    PRESETn,
  input  logic                    PSEL,
  input  logic                    PENABLE,
  input  logic                    PWRITE,
  input  logic [ADDR_WIDTH-1:0]   PADDR,
  input  logic [DATA_WIDTH-1:0]   PWDATA,
`ifdef APB_MEM_PSTRB_EN
  input  logic [DATA_WIDTH/8-1:0] PSTRB,
`endif
  output logic [DATA_WIDTH-1:0]   PRDATA,
  output logic                    PREADY,
  output logic                    PSLVERR
);

  localparam int SW    = DATA_WIDTH / 8;
  localparam int SHIFT = clog2(SW);
  localparam int IDX_W = (DEPTH > 1) ? clog2(DEPTH) : 1;

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  write_q, write_d;
  logic                  err_q, err_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [ADDR_WIDTH-1:0] full_idx;
  logic                  setup, addr_err, ready, wr_en;
  logic [SW-1:0]         wr_be;
  logic [DATA_WIDTH-1:0] rd_data;

  assign full_idx = PADDR >> SHIFT;
  assign addr_err = 32'(full_idx) >= 32'(DEPTH);
  assign setup    = (state_q == IDLE) & PSEL & ~PENABLE;
  assign ready    = (state_q == ACCESS) & (cnt_q == 4'd0);
  // Memory commits only on the completion edge of a non-errored write.
  assign wr_en    = ready & PSEL & PENABLE & write_q & ~err_q;

`ifdef APB_MEM_PSTRB_EN
  assign wr_be = PSTRB;
`else
  assign wr_be = '1;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    write_d = write_q;
    err_d   = err_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (setup) begin
          state_d = ACCESS;
          write_d = PWRITE;
          err_d   = addr_err;
          idx_d   = full_idx[IDX_W-1:0];
          cnt_d   = 4'(WAIT_STATES);
        end
      end
      ACCESS: begin
        if (!PSEL)        state_d = IDLE;
        else if (ready) begin
          if (PENABLE)    state_d = IDLE;
        end
        else              cnt_d = cnt_q - 4'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      write_q <= 1'b0;
      err_q   <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      err_q   <= err_d;
      idx_q   <= idx_d;
    end
  end

  // Out-of-range reads skip the array; err_q masks the stale word to zero.
  apb_mem_array #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH),
    .IDX_W      (IDX_W),
    .SW         (SW)
  ) u_array (
    .clk     (PCLK),
    .rst_n   (PRESETn),
    .rd_en   (setup & ~addr_err),
    .rd_idx  (full_idx[IDX_W-1:0]),
    .rd_data (rd_data),
    .wr_en   (wr_en),
    .wr_idx  (idx_q),
    .wr_be   (wr_be),
    .wr_data (PWDATA)
  );

  assign PRDATA  = err_q ? '0 : rd_data;
  assign PREADY  = ready;
  assign PSLVERR = ready & err_q;

endmodule

// File: tb/tb_apb_mem_slave.sv
// Directed bench for apb_mem_slave: a zero-wait and a 3-wait instance,
// checked against a word model through an expected-response queue.
module tb_apb_mem_slave;

  logic        PCLK = 1'b0;
  logic        PRESETn;
  logic        psel0, psel3, PENABLE, PWRITE;
  logic [9:0]  PADDR;
  logic [31:0] PWDATA;
  logic [3:0]  PSTRB;
  logic [31:0] prdata0, prdata3;
  logic        pready0, pready3, pslverr0, pslverr3;

  always #5 PCLK = ~PCLK;

  apb_mem_slave #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .DEPTH(64), .WAIT_STATES(0)) u0 (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(psel0), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA),
`ifdef APB_MEM_PSTRB_EN
    .PSTRB(PSTRB),
`endif
    .PRDATA(prdata0), .PREADY(pready0), .PSLVERR(pslverr0));

  apb_mem_slave #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .DEPTH(64), .WAIT_STATES(3)) u3 (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(psel3), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA),
`ifdef APB_MEM_PSTRB_EN
    .PSTRB(PSTRB),
`endif
    .PRDATA(prdata3), .PREADY(pready3), .PSLVERR(pslverr3));

  typedef struct {
    logic        rd;
    logic [31:0] data;
    logic        err;
    int          waits;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model [2][64];
  int          total = 0;
  int          bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic logic rdy_of(input int d);
    return (d == 0) ? pready0 : pready3;
  endfunction

  task automatic set_sel(input int d, input logic v);
    if (d == 0) psel0 = v; else psel3 = v;
  endtask

  // Entered and left at the drive slot (1 time unit after a rising edge).
  task automatic xfer(input int d, input logic wr, input logic [9:0] a,
                      input logic [31:0] wd, input logic [3:0] strb, input string tag);
    exp_t        e, got;
    int          idx, n;
    logic        seen;
    logic [31:0] obs_data;
    idx     = int'(a >> 2);
    e.rd    = ~wr;
    e.err   = (idx >= 64);
    e.waits = (d == 0) ? 0 : 3;
    e.data  = (e.err || wr) ? 32'h0 : model[d][idx];
    if (wr && !e.err)
      for (int b = 0; b < 4; b++)
        if (strb[b]) model[d][idx][b*8 +: 8] = wd[b*8 +: 8];
    sb.push_back(e);

    PADDR = a; PWRITE = wr; PWDATA = wd; PSTRB = strb; PENABLE = 1'b0;
    set_sel(d, 1'b1);
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    PADDR   = ~a;  // must be ignored during access
    n = 0; seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge PCLK);
      if (rdy_of(d)) begin seen = 1'b1; break; end
      n++;
      @(posedge PCLK); #1;
    end
    chk({tag, "_ready_seen"}, {31'b0, seen}, 32'd1);
    got = sb.pop_front();
    chk({tag, "_waits"}, 32'(n), 32'(got.waits));
    chk({tag, "_pslverr"}, {31'b0, (d == 0) ? pslverr0 : pslverr3}, {31'b0, got.err});
    if (got.rd) begin
      obs_data = (d == 0) ? prdata0 : prdata3;
      chk({tag, "_prdata"}, obs_data, got.data);
    end
    @(posedge PCLK); #1;
    set_sel(d, 1'b0); PENABLE = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge PCLK); #1; end
  endtask

  initial begin
    PRESETn = 1'b0; psel0 = 0; psel3 = 0; PENABLE = 0; PWRITE = 0;
    PADDR = '0; PWDATA = '0; PSTRB = 4'hF;
    idle(3);
    chk("rst_pready0",  {31'b0, pready0},  32'd0);
    chk("rst_pslverr0", {31'b0, pslverr0}, 32'd0);
    chk("rst_prdata0",  prdata0,           32'd0);
    chk("rst_pready3",  {31'b0, pready3},  32'd0);
    chk("rst_prdata3",  prdata3,           32'd0);
    PRESETn = 1'b1;
    idle(2);

    // Zero-wait write then read
    xfer(0, 1, 10'h010, 32'hDEADBEEF, 4'hF, "zw_wr");
    xfer(0, 0, 10'h010, 32'h0,        4'hF, "zw_rd");

    // Out of range: errored write must not alias onto index 0
    xfer(0, 1, 10'h000, 32'h11111111, 4'hF, "oor_init");
    xfer(0, 1, 10'h100, 32'hAAAA5555, 4'hF, "oor_wr");
    xfer(0, 0, 10'h100, 32'h0,        4'hF, "oor_rd");
    xfer(0, 0, 10'h000, 32'h0,        4'hF, "oor_idx0");
    xfer(0, 0, 10'h3FC, 32'h0,        4'hF, "oor_top");
    xfer(0, 0, 10'h0FC, 32'h0,        4'hF, "last_word");

    // Back-to-back writes, no idle cycle between
    xfer(0, 1, 10'h000, 32'hA0A0A0A0, 4'hF, "b2b_w0");
    xfer(0, 1, 10'h004, 32'h0B0B0B0B, 4'hF, "b2b_w1");
    xfer(0, 0, 10'h000, 32'h0,        4'hF, "b2b_r0");
    xfer(0, 0, 10'h004, 32'h0,        4'hF, "b2b_r1");
    idle(1);

    // Three wait states
    xfer(1, 1, 10'h008, 32'hCAFEF00D, 4'hF, "ws3_wr");
    xfer(1, 0, 10'h008, 32'h0,        4'hF, "ws3_rd");
    idle(1);

    // Abort mid-wait leaves the word unchanged
    xfer(1, 1, 10'h020, 32'h5A5A5A5A, 4'hF, "abt_init");
    PADDR = 10'h020; PWRITE = 1; PWDATA = 32'h99999999; PENABLE = 0; psel3 = 1;
    @(posedge PCLK); #1; PENABLE = 1;
    @(negedge PCLK);
    chk("abt_pready", {31'b0, pready3}, 32'd0);
    @(posedge PCLK); #1; psel3 = 0; PENABLE = 0;
    idle(1);
    xfer(1, 0, 10'h020, 32'h0, 4'hF, "abt_rd");

    // Reset during access drops the pending write
    xfer(1, 0, 10'h008, 32'h0, 4'hF, "rst_pre");
    PADDR = 10'h020; PWRITE = 1; PWDATA = 32'hBAD0BAD0; PENABLE = 0; psel3 = 1;
    @(posedge PCLK); #1; PENABLE = 1;
    @(negedge PCLK);
    PRESETn = 1'b0; #1;
    chk("midrst_pready",  {31'b0, pready3},  32'd0);
    chk("midrst_pslverr", {31'b0, pslverr3}, 32'd0);
    chk("midrst_prdata",  prdata3,           32'd0);
    @(posedge PCLK); #1; psel3 = 0; PENABLE = 0;
    idle(4);
    PRESETn = 1'b1;
    idle(1);
    xfer(1, 0, 10'h020, 32'h0, 4'hF, "midrst_rd");

`ifdef APB_MEM_PSTRB_EN
    xfer(0, 1, 10'h030, 32'hFFFFFFFF, 4'hF,    "strb_init");
    xfer(0, 1, 10'h030, 32'h12345678, 4'b0101, "strb_wr");
    xfer(0, 0, 10'h030, 32'h0,        4'hF,    "strb_rd");
    chk("strb_model", model[0][12], 32'hFF34FF78);
    xfer(0, 1, 10'h030, 32'h00000000, 4'b0000, "strb_noop");
    xfer(0, 0, 10'h030, 32'h0,        4'hF,    "strb_noop_rd");
`endif

    idle(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
